// File: rtl/hv_bundle_encoder.sv
// hv_bundle_encoder
//   Bundles a stream of N binary hypervectors into one hypervector by a
//   per-dimension majority vote. Optional bind mode XORs every sample with a
//   key before counting. Exact ties (2*acc == N) take the matching bit of a
//   programmable tie-break vector.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, begins a bundle (IDLE only)
//   n_samples           sample count N, latched on start (0 -> empty result)
//   mode                0 = plain bundle, 1 = bind-then-bundle, latched on start
//   key_hv, tie_hv      bind key and tie-break bits, latched on start
//   abort               synchronous flush to IDLE (highest priority)
//   in_valid/in_ready   sample handshake, in_hv sample hypervector
//   out_valid/out_ready result handshake, out_hv bundled hypervector
//   busy                block is not IDLE
module hv_bundle_encoder #(
  parameter int DIM   = 1024,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             mode,
  input  logic [DIM-1:0]   key_hv,
  input  logic [DIM-1:0]   tie_hv,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIM-1:0]   in_hv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM-1:0]   out_hv,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] beat_cnt;
  logic             mode_lat;
  logic [DIM-1:0]   key_lat;
  logic [DIM-1:0]   tie_lat;
  logic [CNT_W-1:0] acc [DIM];

  logic [DIM-1:0]   bit_in;
  logic [DIM-1:0]   thr_hv;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  // Majority decision for one dimension. Doubling the count needs one extra
  // bit so the comparison against N is exact, including the tie case.
  function automatic logic thresh_bit(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] n,
                                      input logic             t);
    logic [CNT_W:0] two_a;
    logic [CNT_W:0] n_ext;
    two_a = {a, 1'b0};
    n_ext = {1'b0, n};
    if (two_a > n_ext)       thresh_bit = 1'b1;
    else if (two_a == n_ext) thresh_bit = t;
    else                     thresh_bit = 1'b0;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  assign beat    = in_valid & in_ready;
  assign cnt_inc = beat_cnt + 1'b1;
  assign bit_in  = in_hv ^ (mode_lat ? key_lat : '0);

  always_comb begin
    thr_hv = '0;
    for (int d = 0; d < DIM; d++) begin
      thr_hv[d] = thresh_bit(acc[d], n_lat, tie_lat[d]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_lat    <= '0;
      beat_cnt <= '0;
      mode_lat <= 1'b0;
      key_lat  <= '0;
      tie_lat  <= '0;
      out_hv   <= '0;
      for (int d = 0; d < DIM; d++) acc[d] <= '0;
    end else if (abort) begin
      // Flush counting state but keep the last published result.
      state    <= IDLE;
      beat_cnt <= '0;
      for (int d = 0; d < DIM; d++) acc[d] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (n_samples != '0) begin
              n_lat    <= n_samples;
              mode_lat <= mode;
              key_lat  <= key_hv;
              tie_lat  <= tie_hv;
              beat_cnt <= '0;
              for (int d = 0; d < DIM; d++) acc[d] <= '0;
              state    <= ACCUM;
            end else begin
              out_hv <= '0;
              state  <= OUT;
            end
          end
        end
        // Accumulate: one count per dimension per accepted beat.
        ACCUM: begin
          if (beat) begin
            for (int d = 0; d < DIM; d++) acc[d] <= acc[d] + CNT_W'(bit_in[d]);
            beat_cnt <= cnt_inc;
            if (cnt_inc == n_lat) state <= THRESH;
          end
        end
        // Threshold: register the majority result.
        THRESH: begin
          out_hv <= thr_hv;
          state  <= OUT;
        end
        // Output: hold until the downstream handshake.
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
